// File: rtl/event_latch16.sv
// Sticky 16-bit event latch with a lowest-index-first interrupt request handshake.
// Define EVENT_LATCH16_MASK_EN to add a writable mask register reset to RESET_MASK.
module event_latch16 #(
    parameter logic [15:0] RESET_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ev,
    input  logic [15:0] clr,
    input  logic        mask_we,
    input  logic [15:0] mask_in,
    input  logic        irq_ack,
    output logic [15:0] pending,
    output logic        irq_req,
    output logic [3:0]  irq_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic        irq_req_q, irq_req_d;
    logic [3:0]  irq_id_q, irq_id_d;
    logic [15:0] mask;
    logic [15:0] eff;
    logic [15:0] ack_clr;
    logic [3:0]  low_idx;

`ifdef EVENT_LATCH16_MASK_EN
    logic [15:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (mask_we) begin
            mask_d = mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= RESET_MASK;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mask_we, mask_in, RESET_MASK};
    assign mask       = 16'hFFFF;
`endif

    assign eff = pending_q & mask;

    // An acknowledge only retires the bit being requested, and only while requesting.
    always_comb begin
        ack_clr = 16'h0000;
        if (state_q == ST_REQ && irq_ack) begin
            ack_clr = 16'h0001 << irq_id_q;
        end
    end

    // Scan from the top so the lowest set index is the last one to assign.
    always_comb begin
        low_idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (eff[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    assign pending_d = (pending_q & ~clr & ~ack_clr) | ev;

    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (eff != 16'h0000) begin
                    state_d   = ST_REQ;
                    irq_req_d = 1'b1;
                    irq_id_d  = low_idx;
                end else begin
                    irq_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                // Acknowledge outranks a software clear of the requested bit.
                if (irq_ack) begin
                    state_d   = ST_DONE;
                    irq_req_d = 1'b0;
                end else if (clr[irq_id_q] && !ev[irq_id_q]) begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                end else begin
                    irq_req_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                irq_req_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 16'h0000;
            irq_req_q <= 1'b0;
            irq_id_q  <= 4'h0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign pending = pending_q;
    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_event_latch16.sv
// Directed self-checking bench for event_latch16; expectations are hand-computed
// per step and follow the EVENT_LATCH16_MASK_EN setting of the build.
module tb_event_latch16;

    logic        clk;
    logic        rst_n;
    logic [15:0] ev;
    logic [15:0] clr;
    logic        mask_we;
    logic [15:0] mask_in;
    logic        irq_ack;
    logic [15:0] pending;
    logic        irq_req;
    logic [3:0]  irq_id;

    int checks;
    int failures;

    event_latch16 #(.RESET_MASK(16'hFFFF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev      (ev),
        .clr     (clr),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .irq_ack (irq_ack),
        .pending (pending),
        .irq_req (irq_req),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the rising edge, then sample 1 time unit later.
    task automatic applyStimulus(input logic r, input logic [15:0] e, input logic [15:0] c,
                                 input logic mw, input logic [15:0] mi, input logic a);
        rst_n   = r;
        ev      = e;
        clr     = c;
        mask_we = mw;
        mask_in = mi;
        irq_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; ev = '0; clr = '0; mask_we = 1'b0; mask_in = '0; irq_ack = 1'b0;
        #1;

        // Reset with every input active: all of it must be discarded.
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        checkOutput("rst_pending", pending, 16'h0000);
        checkOutput("rst_req", {15'h0, irq_req}, 16'h0000);
        checkOutput("rst_id", {12'h0, irq_id}, 16'h0000);

        // Single event, latency of one edge to pending, two to request.
        applyStimulus(1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ev4_pending", pending, 16'h0010);
        checkOutput("ev4_req_early", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ev4_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("ev4_id", {12'h0, irq_id}, 16'h0004);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("ev4_ack_pending", pending, 16'h0000);
        checkOutput("ev4_ack_req", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Two events at once: bit 0 served first, DONE gap, then bit 15.
        applyStimulus(1'b1, 16'h8001, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("two_pending", pending, 16'h8001);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("two_req0", {15'h0, irq_req}, 16'h0001);
        checkOutput("two_id0", {12'h0, irq_id}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("two_ack0_pending", pending, 16'h8000);
        checkOutput("two_ack0_req", {15'h0, irq_req}, 16'h0000);
        // Acknowledge held through DONE must not retire bit 15.
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("two_done_pending", pending, 16'h8000);
        checkOutput("two_done_req", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("two_req15", {15'h0, irq_req}, 16'h0001);
        checkOutput("two_id15", {12'h0, irq_id}, 16'h000F);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("two_ack15_pending", pending, 16'h0000);
        checkOutput("two_ack15_req", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("two_idle_req", {15'h0, irq_req}, 16'h0000);

        // Ack and re-set of the same bit at one edge: set wins, request repeats.
        applyStimulus(1'b1, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("id3_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("id3_id", {12'h0, irq_id}, 16'h0003);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0);
        checkOutput("id3_maskchg_req", {15'h0, irq_req}, 16'h0001);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
        checkOutput("id3_maskrst_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("id3_maskrst_id", {12'h0, irq_id}, 16'h0003);
        applyStimulus(1'b1, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("id3_setwins_pending", pending, 16'h0008);
        checkOutput("id3_done_req", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("id3_idle_req", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("id3_rereq", {15'h0, irq_req}, 16'h0001);
        checkOutput("id3_reid", {12'h0, irq_id}, 16'h0003);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        checkOutput("id3_final_pending", pending, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Software clear of the requested bit cancels the request.
        applyStimulus(1'b1, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("id2_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("id2_id", {12'h0, irq_id}, 16'h0002);
        applyStimulus(1'b1, 16'h0000, 16'h0004, 1'b0, 16'h0000, 1'b0);
        checkOutput("cancel_req", {15'h0, irq_req}, 16'h0000);
        checkOutput("cancel_pending", pending, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("cancel_idle_req", {15'h0, irq_req}, 16'h0000);

        // Mask out bit 0, then raise it.
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFE, 1'b0);
        applyStimulus(1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("mask_pending", pending, 16'h0001);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
`ifdef EVENT_LATCH16_MASK_EN
        checkOutput("mask_req_blocked", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("mask_req_still_blocked", {15'h0, irq_req}, 16'h0000);
`else
        checkOutput("nomask_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("nomask_id", {12'h0, irq_id}, 16'h0000);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("nomask_hold_id", {12'h0, irq_id}, 16'h0000);
`endif

        // Fill everything, be requesting, then reset.
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("full_pending", pending, 16'hFFFF);
        checkOutput("full_req", {15'h0, irq_req}, 16'h0001);
`ifdef EVENT_LATCH16_MASK_EN
        checkOutput("full_id", {12'h0, irq_id}, 16'h0001);
`else
        checkOutput("full_id", {12'h0, irq_id}, 16'h0000);
`endif
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("rst2_pending", pending, 16'h0000);
        checkOutput("rst2_req", {15'h0, irq_req}, 16'h0000);
        checkOutput("rst2_id", {12'h0, irq_id}, 16'h0000);
        // After reset the mask is all-ones again, so bit 0 requests.
        applyStimulus(1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("rst2_mask_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("rst2_mask_id", {12'h0, irq_id}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
